// File: rtl/ws2812_pkg.sv
// ---------------------------------------------------------------------------
// ws2812_pkg
// Shared types and helpers for the WS2812 frame buffer slice.
//   rgb_t / grb_t : host-side and wire-side pixel layouts
//   state_t       : frame sequencer states
//   scale_channel / scale_pixel : global brightness scaling
//   FRAME_CYCLES  : frame period for the default clock and frame rate
// ---------------------------------------------------------------------------
package ws2812_pkg;

    localparam int DEFAULT_CLK_FRE  = 27_000_000;
    localparam int DEFAULT_FRAME_HZ = 10;
    localparam int FRAME_CYCLES     = DEFAULT_CLK_FRE / DEFAULT_FRAME_HZ;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } grb_t;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    // Multiplying by (bright + 1) lets 255 map to an exact passthrough while
    // keeping the product inside 16 bits (255 * 256 = 65280).
    function automatic logic [7:0] scale_channel(input logic [7:0] c,
                                                 input logic [7:0] bright);
        logic [8:0]  mult;
        logic [15:0] prod;
        mult = {1'b0, bright} + 9'd1;
        prod = {8'd0, c} * {7'd0, mult};
        return 8'(prod >> 8);
    endfunction

    function automatic grb_t scale_pixel(input rgb_t px, input logic [7:0] bright);
        grb_t o;
        o.g = scale_channel(px.g, bright);
        o.r = scale_channel(px.r, bright);
        o.b = scale_channel(px.b, bright);
        return o;
    endfunction

endpackage

// File: rtl/ws2812_frame_timer.sv
// ---------------------------------------------------------------------------
// ws2812_frame_timer
// Free-running counter over 0..CYCLES-1 that marks each frame boundary.
//   clk  : system clock
//   rst  : asynchronous active-high reset, counter restarts from 0
//   tick : high for one cycle while the counter sits on its last value
// ---------------------------------------------------------------------------
module ws2812_frame_timer
    import ws2812_pkg::*;
#(
    parameter int CYCLES = FRAME_CYCLES
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int            CW   = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic [CW-1:0] count;

    assign tick = (count == LAST);

    // Period counter; wraps to zero on the tick cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ws2812_frame_buffer.sv
// ---------------------------------------------------------------------------
// ws2812_frame_buffer
// Double-buffered pixel store and frame sequencer feeding the WS2812
// serializer. Host writes go to the back bank; commit swaps banks at the next
// frame start; each frame streams the front bank as brightness-scaled GRB.
//   clk, rst            : clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_rgb: host pixel write into the back bank
//   commit              : request a bank swap at the next frame start
//   brightness          : global scale, latched at frame start
//   out_valid/out_ready : word handshake towards the serializer
//   out_data/out_last   : scaled {G,R,B} word, last-pixel marker
//   busy                : high while streaming
//   frame_done          : one-cycle pulse after the final handshake
//   overrun             : one-cycle pulse when a tick arrives mid-stream
// ---------------------------------------------------------------------------
module ws2812_frame_buffer
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS = 3,
    parameter int ADDR_W   = 9,
    parameter int CLK_FRE  = 27_000_000,
    parameter int FRAME_HZ = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [23:0]       wr_rgb,
    input  logic              commit,
    input  logic [7:0]        brightness,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [23:0]       out_data,
    output logic              out_last,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun
);

    localparam int                PERIOD   = CLK_FRE / FRAME_HZ;
    localparam int                IDX_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_LEDS - 1);
    localparam logic [ADDR_W:0]   NUM_W    = (ADDR_W + 1)'(NUM_LEDS);

    rgb_t              bank [0:1][0:NUM_LEDS-1];
    state_t            state, state_next;
    logic              front, swap_pending;
    logic [ADDR_W-1:0] idx, idx_next;
    logic [7:0]        bright_q, scale_b;
    logic              tick, handshake, last_hs, start, swap, front_next, wr_ok;
    rgb_t              rd_px;
    logic              out_valid_d, out_last_d, frame_done_d, overrun_d;
    grb_t              out_data_d;

    ws2812_frame_timer #(
        .CYCLES(PERIOD)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    assign handshake = out_valid && out_ready;
    assign last_hs   = handshake && (idx == LAST_IDX);
    assign wr_ok     = wr_en && ({1'b0, wr_addr} < NUM_W);
    assign scale_b   = start ? brightness : bright_q;

    // Pixel banks; host writes always land in the bank not being streamed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < NUM_LEDS; i++) begin
                    bank[b][i] <= '0;
                end
            end
        end else if (wr_ok) begin
            bank[~front][wr_addr[IDX_W-1:0]] <= wr_rgb;
        end
    end

    // Frame-start decisions and the address of the next word to present.
    // On a swapping frame start the host may be writing the bank that is about
    // to become front in this same cycle, so that write is forwarded.
    always_comb begin
        start      = (state == IDLE) && tick;
        swap       = start && (swap_pending || commit);
        front_next = front ^ swap;
        idx_next   = idx;
        if (start) begin
            idx_next = '0;
        end else if (handshake && !last_hs) begin
            idx_next = idx + 1'b1;
        end
        rd_px = bank[front_next][idx_next[IDX_W-1:0]];
        if (wr_ok && ((~front) == front_next) && (wr_addr == idx_next)) begin
            rd_px = wr_rgb;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (tick)    state_next = STREAM;
            STREAM:  if (last_hs) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Next values of the registered outputs; out_data only moves when a new
    // word is presented so it stays stable under backpressure.
    always_comb begin
        out_valid_d  = (state_next == STREAM);
        out_last_d   = (state_next == STREAM) && (idx_next == LAST_IDX);
        frame_done_d = last_hs;
        overrun_d    = (state == STREAM) && tick;
        out_data_d   = out_data;
        if (start || (handshake && !last_hs)) begin
            out_data_d = scale_pixel(rd_px, scale_b);
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            out_valid  <= out_valid_d;
            out_data   <= out_data_d;
            out_last   <= out_last_d;
            busy       <= out_valid_d;
            frame_done <= frame_done_d;
            overrun    <= overrun_d;
        end
    end

    // Bank select, swap request, pixel index and per-frame brightness.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            front        <= 1'b0;
            swap_pending <= 1'b0;
            idx          <= '0;
            bright_q     <= '0;
        end else begin
            front        <= front_next;
            swap_pending <= swap ? 1'b0 : (swap_pending || commit);
            idx          <= idx_next;
            if (start) begin
                bright_q <= brightness;
            end
        end
    end

endmodule

// File: doc/ws2812_frame_buffer.md
# ws2812_frame_buffer

Double-buffered pixel store and frame sequencer that sits directly upstream of the WS2812 bit serializer. A host writes RGB pixels into a back bank and commits them. On every frame tick the block streams the front bank, one 24-bit GRB word per LED, over a valid/ready handshake. Global brightness scaling is applied on the way out.

## Interface
- NUM_LEDS, 3, number of LEDs in the chain (1..512)
- ADDR_W, 9, pixel address width; must satisfy 2^ADDR_W >= NUM_LEDS
- CLK_FRE, 27_000_000, clock frequency in Hz
- FRAME_HZ, 10, frame rate; frame period is CLK_FRE/FRAME_HZ cycles
- clk  in  1  system clock; all logic is on the rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  host pixel write strobe
- wr_addr  in  ADDR_W  pixel index
- wr_rgb  in  24  {R[23:16], G[15:8], B[7:0]}
- commit  in  1  single-cycle request to swap banks at the next frame start
- brightness  in  8  global scale
- out_valid  out  1  pixel word available
- out_ready  in  1  serializer accepts the word
- out_data  out  24  scaled pixel, {G, R, B}, sent MSB first downstream
- out_last  out  1  marks pixel NUM_LEDS-1
- busy  out  1  high while in STREAM
- frame_done  out  1  one-cycle pulse after the last handshake
- overrun  out  1  one-cycle pulse when a tick hits during STREAM

## Operation
- Storage: two banks of NUM_LEDS x 24 registers.
  - front selects the bank being streamed; the back bank is !front.
  - Writes always go to the back bank.
  - A write with wr_addr >= NUM_LEDS is ignored.
- Frame timer: free-running counter over 0..CLK_FRE/FRAME_HZ-1. It emits a one-cycle tick on wrap.
- commit sets swap_pending. The flag stays set until consumed. Repeated commits are idempotent.
- FSM states:
  - IDLE: on tick, if swap_pending then toggle front and clear swap_pending. Then latch brightness into bright_q, set idx=0 and go to STREAM.
  - STREAM: present pixel idx. On out_valid && out_ready:
    - if idx == NUM_LEDS-1, go to IDLE and pulse frame_done;
    - otherwise idx++.
  - A tick in STREAM is dropped and pulses overrun.
- Scaling, per channel c (8 bit): (c * (bright_q + 1)) >> 8.
  - Uses a 16-bit product (9-bit multiplier).
  - brightness = 255 gives exact passthrough; brightness = 0 gives c >> 8 = 0.
- Reorder: out_data = {Gs, Rs, Bs}.
- bright_q is constant for the whole frame. Changes to brightness mid-frame take effect next frame.
- Simultaneous events:
  - wr_en and commit in the same cycle: the write lands in the pre-swap back bank, so it is included in the swapped frame.
  - commit on the same cycle as a tick in IDLE: the swap is taken this frame.
  - Writes during STREAM never alter the bank being streamed.

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_last=0, busy=0, frame_done=0, overrun=0.
  - front=0, swap_pending=0, idx=0, timer=0, bright_q=0.
  - All pixel registers are 0.
- Reset asserted mid-frame: outputs drop asynchronously. The first tick after release occurs CLK_FRE/FRAME_HZ cycles later.
- All outputs are registered.
- Tick at cycle T (IDLE): at T+1, busy=1, out_valid=1, out_data = pixel 0.
- Handshake at cycle H (not last): pixel idx+1 is on out_data at H+1. out_valid stays high, so there are no bubbles.
- While out_valid && !out_ready, out_data and out_last hold stable.
- Handshake on last at cycle H: at H+1, out_valid=0, out_last=0, busy=0, frame_done=1 for exactly one cycle.
- out_last=1 only when the presented word is index NUM_LEDS-1.
  - With NUM_LEDS=1, out_last is high with the first word.
- Write latency: a pixel written at cycle W is visible in the back bank at W+1.

## Structure
- Package ws2812_pkg holds:
  - the rgb_t / grb_t packed structs;
  - the FSM state enum {IDLE, STREAM};
  - the scale function;
  - the localparam FRAME_CYCLES = CLK_FRE/FRAME_HZ.
- Sub-module ws2812_frame_timer (clk, rst, tick) holds the free-running period counter. Everything else stays in the top.

## Test plan
- Reset, write LED0=0x112233 and LED2=0xFFFFFF, commit, brightness=255, out_ready=1:
  - next frame yields 0x221133, 0x000000, 0xFFFFFF;
  - out_last on word 3; frame_done one cycle later.
- brightness=127, pixel 0x80FF01: out_data = {0x7F, 0x40, 0x00}.
- Backpressure: drop out_ready for 5 cycles mid-frame. out_data holds, no word is skipped or duplicated, and the order is intact.
- Commit and write LED1 during STREAM: the current frame is unchanged; the next frame shows the new LED1.
- Small FRAME_CYCLES (e.g. 4) with out_ready=0: overrun pulses once per tick and busy stays high.
- wr_addr=NUM_LEDS with wr_en: no pixel changes.
- Assert rst mid-frame: out_valid=0 immediately. The first frame after release streams all zeros, because the pixel registers are cleared.
